// File: rtl/cache_sim_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cache_sim_pkg
// Brief    : Shared types, LFSR constants and address-split helper for the
//            tag-only cache policy model.
// Revision : 1.0 - initial release
// ============================================================================
package cache_sim_pkg;

    typedef enum logic [1:0] {
        REPL_LRU    = 2'd0,
        REPL_FIFO   = 2'd1,
        REPL_RANDOM = 2'd2
    } repl_policy_e;

    typedef enum logic {
        WB_WA  = 1'b0,
        WT_NWA = 1'b1
    } write_policy_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_UPDATE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    // Fibonacci LFSR, taps 16,14,13,11 map to bit positions 15,13,12,10.
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    typedef struct packed {
        int off_w;
        int idx_w;
        int tag_w;
    } addr_split_t;

    function automatic addr_split_t calc_split(input int cache_size, input int line_size,
                                               input int assoc, input int addr_w);
        addr_split_t s;
        s.off_w = $clog2(line_size);
        s.idx_w = $clog2(cache_size / (line_size * assoc));
        s.tag_w = addr_w - s.off_w - s.idx_w;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_repl_unit.sv
`default_nettype none
// ============================================================================
// Module   : cache_repl_unit
// Brief    : Per-set replacement state (LRU ages, FIFO pointers or LFSR) with
//            victim selection and touch/allocate/clear update ports.
// Revision : 1.0 - initial release
// ============================================================================
module cache_repl_unit
    import cache_sim_pkg::*;
#(
    parameter int NUM_SETS    = 64,
    parameter int ASSOC       = 4,
    parameter int REPL_POLICY = 0,
    parameter int SET_W       = 6,
    parameter int WAY_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] lookup_set,
    output logic [WAY_W-1:0] victim_way,
    input  logic             touch_en,
    input  logic             alloc_en,
    input  logic [SET_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way,
    input  logic             clear_en,
    input  logic [SET_W-1:0] clear_set
);

    localparam repl_policy_e c_policy = repl_policy_e'(REPL_POLICY[1:0]);

    // Not every policy consumes every update port.
    logic w_unused_ports;
    assign w_unused_ports = ^{lookup_set, touch_en, alloc_en, upd_set, upd_way,
                              clear_en, clear_set};

    generate
        if (c_policy == REPL_LRU) begin : g_lru
            logic [WAY_W-1:0] r_age [NUM_SETS][ASSOC];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < NUM_SETS; s++)
                        for (int w = 0; w < ASSOC; w++)
                            r_age[s][w] <= WAY_W'(w);
                end else if (clear_en) begin
                    for (int w = 0; w < ASSOC; w++)
                        r_age[clear_set][w] <= WAY_W'(w);
                end else if (touch_en) begin
                    for (int w = 0; w < ASSOC; w++)
                        if (r_age[upd_set][w] > r_age[upd_set][upd_way])
                            r_age[upd_set][w] <= r_age[upd_set][w] - WAY_W'(1);
                    r_age[upd_set][upd_way] <= WAY_W'(ASSOC - 1);
                end
            end

            // Ages are always a permutation, so exactly one way holds age 0.
            always_comb begin
                victim_way = '0;
                for (int w = 0; w < ASSOC; w++)
                    if (r_age[lookup_set][w] == '0)
                        victim_way = WAY_W'(w);
            end
        end else if (c_policy == REPL_FIFO) begin : g_fifo
            logic [WAY_W-1:0] r_ptr [NUM_SETS];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < NUM_SETS; s++)
                        r_ptr[s] <= '0;
                end else if (clear_en) begin
                    r_ptr[clear_set] <= '0;
                end else if (alloc_en) begin
                    r_ptr[upd_set] <= r_ptr[upd_set] + WAY_W'(1);
                end
            end

            assign victim_way = r_ptr[lookup_set];
        end else begin : g_random
            logic [15:0] r_lfsr;

            always_ff @(posedge clk) begin
                if (rst)
                    r_lfsr <= c_lfsr_seed;
                else
                    r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & c_lfsr_taps)};
            end

            assign victim_way = r_lfsr[WAY_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cache_policy_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_policy_controller
// Brief    : Tag-only set-associative cache model with request handshake,
//            selectable replacement/write policies, dirty tracking and flush.
// Revision : 1.0 - initial release
// ============================================================================
module cache_policy_controller
    import cache_sim_pkg::*;
#(
    parameter int CACHE_SIZE    = 8192,
    parameter int LINE_SIZE     = 32,
    parameter int ASSOCIATIVITY = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int REPL_POLICY   = 0,
    parameter int WRITE_POLICY  = 0,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,
    output logic                  busy,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic                  resp_wb,
    output logic [CNT_W-1:0]      hits,
    output logic [CNT_W-1:0]      misses,
    output logic [CNT_W-1:0]      writebacks,
    output logic [CNT_W-1:0]      write_throughs
);

    localparam int          c_num_sets = CACHE_SIZE / (LINE_SIZE * ASSOCIATIVITY);
    localparam addr_split_t c_split    = calc_split(CACHE_SIZE, LINE_SIZE, ASSOCIATIVITY, ADDR_WIDTH);
    localparam int          c_off_w    = c_split.off_w;
    localparam int          c_idx_w    = c_split.idx_w;
    localparam int          c_tag_w    = c_split.tag_w;
    localparam int          c_set_w    = (c_idx_w > 0) ? c_idx_w : 1;
    localparam int          c_way_w    = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;
    localparam int          c_pop_w    = c_way_w + 1;
    localparam write_policy_e    c_wp  = (WRITE_POLICY == 1) ? WT_NWA : WB_WA;
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_e               r_state, w_next_state;
    logic                 r_we, r_hit;
    logic [c_tag_w-1:0]   r_tag;
    logic [c_set_w-1:0]   r_set, r_flush_set;
    logic [c_way_w-1:0]   r_way;

    logic [c_tag_w-1:0]       r_tag_mem [c_num_sets][ASSOCIATIVITY];
    logic [ASSOCIATIVITY-1:0] r_valid   [c_num_sets];
    logic [ASSOCIATIVITY-1:0] r_dirty   [c_num_sets];

    logic [c_tag_w-1:0]   w_req_tag;
    logic [c_set_w-1:0]   w_req_set;
    logic                 w_unused_offset;
    logic                 w_accept, w_upd, w_alloc, w_evict_wb, w_touch, w_set_dirty;
    logic                 w_hit, w_inv_found;
    logic [c_way_w-1:0]   w_hit_way, w_inv_way, w_repl_victim;
    logic [c_pop_w-1:0]   w_flush_wbs;

    assign w_req_tag       = req_addr[ADDR_WIDTH-1 -: c_tag_w];
    assign w_unused_offset = ^req_addr[c_off_w-1:0];

    generate
        if (c_idx_w > 0) begin : g_indexed
            assign w_req_set = req_addr[c_off_w +: c_idx_w];
        end else begin : g_fully_assoc
            assign w_req_set = '0;
        end
    endgenerate

    // FSM ----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (flush)
                    w_next_state = ST_FLUSH;
                else if (req_valid)
                    w_next_state = ST_LOOKUP;
            end
            ST_LOOKUP: w_next_state = ST_UPDATE;
            ST_UPDATE: w_next_state = ST_IDLE;
            ST_FLUSH: begin
                busy = 1'b1;
                if (r_flush_set == c_set_w'(c_num_sets - 1))
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && req_valid && !flush;

    // Tag compare and free-way search; descending scan lets the lowest way win.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (r_valid[r_set][w] && (r_tag_mem[r_set][w] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_way_w'(w);
            end
            if (!r_valid[r_set][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_way_w'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_tag       <= '0;
            r_set       <= '0;
            r_hit       <= 1'b0;
            r_way       <= '0;
            r_flush_set <= '0;
        end else begin
            if (w_accept) begin
                r_we  <= req_we;
                r_tag <= w_req_tag;
                r_set <= w_req_set;
            end
            if (r_state == ST_LOOKUP) begin
                r_hit <= w_hit;
                r_way <= w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_repl_victim);
            end
            if (r_state == ST_FLUSH)
                r_flush_set <= (r_flush_set == c_set_w'(c_num_sets - 1)) ? '0
                                                                          : r_flush_set + c_set_w'(1);
        end
    end

    // Update-phase decode ------------------------------------------------------
    assign w_upd       = (r_state == ST_UPDATE);
    assign w_alloc     = w_upd && !r_hit && (!r_we || (c_wp == WB_WA));
    assign w_evict_wb  = w_alloc && r_valid[r_set][r_way] && r_dirty[r_set][r_way];
    assign w_touch     = w_upd && (r_hit || w_alloc);
    assign w_set_dirty = w_upd && r_we && (c_wp == WB_WA);
    assign w_flush_wbs = c_pop_w'($countones(r_valid[r_flush_set] & r_dirty[r_flush_set]));

    cache_repl_unit #(
        .NUM_SETS    (c_num_sets),
        .ASSOC       (ASSOCIATIVITY),
        .REPL_POLICY (REPL_POLICY),
        .SET_W       (c_set_w),
        .WAY_W       (c_way_w)
    ) u_repl (
        .clk        (clk),
        .rst        (rst),
        .lookup_set (r_set),
        .victim_way (w_repl_victim),
        .touch_en   (w_touch),
        .alloc_en   (w_alloc),
        .upd_set    (r_set),
        .upd_way    (r_way),
        .clear_en   (r_state == ST_FLUSH),
        .clear_set  (r_flush_set)
    );

    always_ff @(posedge clk) begin
        if (!rst && w_alloc)
            r_tag_mem[r_set][r_way] <= r_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < c_num_sets; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (r_state == ST_FLUSH) begin
            r_valid[r_flush_set] <= '0;
            r_dirty[r_flush_set] <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[r_set][r_way] <= 1'b1;
                r_dirty[r_set][r_way] <= 1'b0;
            end
            if (w_set_dirty)
                r_dirty[r_set][r_way] <= 1'b1;
        end
    end

    // Response strobe and statistics ----------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_wb        <= 1'b0;
            hits           <= '0;
            misses         <= '0;
            writebacks     <= '0;
            write_throughs <= '0;
        end else begin
            resp_valid <= w_upd;
            if (w_upd) begin
                resp_hit <= r_hit;
                resp_wb  <= w_evict_wb;
                if (r_hit)
                    hits <= hits + c_one;
                else
                    misses <= misses + c_one;
                if (w_evict_wb)
                    writebacks <= writebacks + c_one;
                if (r_we && (c_wp == WT_NWA))
                    write_throughs <= write_throughs + c_one;
            end else if (r_state == ST_FLUSH) begin
                writebacks <= writebacks + CNT_W'(w_flush_wbs);
            end
        end
    end

endmodule
`default_nettype wire
